// File: rtl/stream_demultiplexer.sv
// 1-to-2 packet demux: destination locked at the first beat of each packet.
// Packet counters are built only when STREAM_DEMUX_PKT_COUNT_EN is defined.
module stream_demultiplexer #(
   parameter int WORD_LENGHT = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Selector,
   input  logic [WORD_LENGHT-1:0] Data_In,
   input  logic                   In_Valid,
   input  logic                   In_Last,
   output logic                   In_Ready,
   output logic [WORD_LENGHT-1:0] Data_0,
   output logic [WORD_LENGHT-1:0] Data_1,
   output logic                   Valid_0,
   output logic                   Valid_1,
   output logic                   Last_0,
   output logic                   Last_1,
   input  logic                   Ready_0,
   input  logic                   Ready_1,
   output logic [COUNT_WIDTH-1:0] Packet_Count_0,
   output logic [COUNT_WIDTH-1:0] Packet_Count_1
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROUTE_0 = 2'd1,
      ROUTE_1 = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                   dest;
   logic                   accept;
   logic                   ld0, ld1;
   logic                   v0_q, v1_q;
   logic                   l0_q, l1_q;
   logic [WORD_LENGHT-1:0] d0_q, d1_q;

   always_comb begin
      dest     = Selector;
      state_d  = state_q;
      unique case (state_q)
         ROUTE_0: dest = 1'b0;
         ROUTE_1: dest = 1'b1;
         default: dest = Selector;
      endcase
      // Readiness only looks at the port this beat is heading to
      In_Ready = dest ? (!v1_q || Ready_1) : (!v0_q || Ready_0);
      accept   = In_Valid && In_Ready;
      if (accept) begin
         if (state_q == IDLE) begin
            if (!In_Last) state_d = dest ? ROUTE_1 : ROUTE_0;
         end else if (In_Last) begin
            state_d = IDLE;
         end
      end
   end

   assign ld0 = accept && !dest;
   assign ld1 = accept && dest;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         l0_q    <= 1'b0;
         l1_q    <= 1'b0;
         d0_q    <= '0;
         d1_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ld0) begin
            d0_q <= Data_In;
            l0_q <= In_Last;
            v0_q <= 1'b1;
         end else if (v0_q && Ready_0) begin
            v0_q <= 1'b0;
         end
         if (ld1) begin
            d1_q <= Data_In;
            l1_q <= In_Last;
            v1_q <= 1'b1;
         end else if (v1_q && Ready_1) begin
            v1_q <= 1'b0;
         end
      end
   end

   assign Data_0  = d0_q;
   assign Data_1  = d1_q;
   assign Valid_0 = v0_q;
   assign Valid_1 = v1_q;
   assign Last_0  = l0_q;
   assign Last_1  = l1_q;

`ifdef STREAM_DEMUX_PKT_COUNT_EN
   logic [COUNT_WIDTH-1:0] c0_q, c1_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c0_q <= '0;
         c1_q <= '0;
      end else begin
         if (v0_q && Ready_0 && l0_q) c0_q <= c0_q + COUNT_WIDTH'(1);
         if (v1_q && Ready_1 && l1_q) c1_q <= c1_q + COUNT_WIDTH'(1);
      end
   end

   assign Packet_Count_0 = c0_q;
   assign Packet_Count_1 = c1_q;
`else
   assign Packet_Count_0 = '0;
   assign Packet_Count_1 = '0;
`endif

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Random traffic bench for stream_demultiplexer with a queue-based
// scoreboard; directed reset, single-beat and counter-wrap scenarios.
module tb_stream_demultiplexer;

   localparam int W  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          Selector;
   logic [W-1:0]  Data_In;
   logic          In_Valid;
   logic          In_Last;
   logic          In_Ready;
   logic [W-1:0]  Data_0, Data_1;
   logic          Valid_0, Valid_1;
   logic          Last_0, Last_1;
   logic          Ready_0, Ready_1;
   logic [CW-1:0] Packet_Count_0, Packet_Count_1;

   stream_demultiplexer #(.WORD_LENGHT(W), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .Selector(Selector),
      .Data_In(Data_In), .In_Valid(In_Valid), .In_Last(In_Last),
      .In_Ready(In_Ready),
      .Data_0(Data_0), .Data_1(Data_1),
      .Valid_0(Valid_0), .Valid_1(Valid_1),
      .Last_0(Last_0), .Last_1(Last_1),
      .Ready_0(Ready_0), .Ready_1(Ready_1),
      .Packet_Count_0(Packet_Count_0), .Packet_Count_1(Packet_Count_1)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Scoreboard: beats owed to each port, packet lock, delivered packets
   logic [W:0]    q0[$], q1[$];
   bit            in_pkt;
   bit            pkt_dest;
   logic [CW-1:0] pk0, pk1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] c);
`ifdef STREAM_DEMUX_PKT_COUNT_EN
      return c;
`else
      return '0;
`endif
   endfunction

   task automatic model_clear();
      q0.delete();
      q1.delete();
      in_pkt = 0;
      pkt_dest = 0;
      pk0 = '0;
      pk1 = '0;
   endtask

   // Check outputs mid-cycle, then advance the model to the next edge
   task automatic step();
      bit d, rdy, take;
      logic [W:0] b;
      @(negedge clk);
      chk("valid0", Valid_0, q0.size() != 0);
      chk("valid1", Valid_1, q1.size() != 0);
      if (q0.size() != 0) chk("beat0", {Last_0, Data_0}, q0[0]);
      if (q1.size() != 0) chk("beat1", {Last_1, Data_1}, q1[0]);
      chk("cnt0", Packet_Count_0, exp_cnt(pk0));
      chk("cnt1", Packet_Count_1, exp_cnt(pk1));
      d    = in_pkt ? pkt_dest : Selector;
      rdy  = d ? (q1.size() == 0 || Ready_1) : (q0.size() == 0 || Ready_0);
      chk("in_ready", In_Ready, rdy);
      take = In_Valid && rdy;
      if (q0.size() != 0 && Ready_0) begin
         b = q0.pop_front();
         if (b[W]) pk0++;
      end
      if (q1.size() != 0 && Ready_1) begin
         b = q1.pop_front();
         if (b[W]) pk1++;
      end
      if (take) begin
         if (d) q1.push_back({In_Last, Data_In});
         else   q0.push_back({In_Last, Data_In});
         if (!in_pkt && !In_Last) begin
            in_pkt = 1;
            pkt_dest = d;
         end else if (in_pkt && In_Last) begin
            in_pkt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit s, input logic [W-1:0] d,
                        input bit l, input bit r0, input bit r1);
      In_Valid = v;
      Selector = s;
      Data_In  = d;
      In_Last  = l;
      Ready_0  = r0;
      Ready_1  = r1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, '0, 0, 0, 0);
      model_clear();
      reset = 1'b0;
      #2;
      chk("rst_valid0", Valid_0, 1'b0);
      chk("rst_data0", Data_0, 8'h00);
      chk("rst_last1", Last_1, 1'b0);
      chk("rst_cnt0", Packet_Count_0, 8'h00);
      do_reset();

      // Single-beat packet to port 1
      drive(1, 1, 8'hA5, 1, 1, 1);
      step();
      drive(0, 0, 8'h00, 0, 1, 1);
      chk("sb_data1", Data_1, 8'hA5);
      chk("sb_valid0", Valid_0, 1'b0);
      step();
      step();
      chk("sb_cnt1", Packet_Count_1, exp_cnt(8'd1));

      // Packet lock while Selector toggles
      drive(1, 0, 8'h10, 0, 1, 1); step();
      drive(1, 1, 8'h11, 0, 1, 1); step();
      drive(1, 1, 8'h12, 1, 1, 1); step();
      drive(0, 1, 8'h00, 0, 1, 1); step(); step();
      chk("lock_cnt0", Packet_Count_0, exp_cnt(8'd1));

      // Backpressure on port 0, port 1 stalled independently
      drive(1, 0, 8'h33, 1, 0, 0); step();
      drive(1, 1, 8'h77, 1, 0, 0); step();
      drive(1, 0, 8'h34, 1, 0, 0); step(); step();
      chk("bp_hold", Data_0, 8'h33);
      drive(1, 0, 8'h34, 1, 1, 0); step();
      drive(0, 0, 8'h00, 0, 1, 0); step(); step();
      chk("bp_p1", Data_1, 8'h77);

      // Asynchronous reset while routing a packet to port 1
      drive(1, 1, 8'h5C, 0, 1, 0); step(); step();
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid1", Valid_1, 1'b0);
      chk("ar_data1", Data_1, 8'h00);
      chk("ar_cnt0", Packet_Count_0, 8'h00);
      chk("ar_cnt1", Packet_Count_1, 8'h00);
      drive(0, 0, 8'h00, 0, 1, 1);
      model_clear();
      @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 0, 8'h66, 1, 1, 1); step();
      drive(0, 0, 8'h00, 0, 1, 1);
      chk("ar_p0", Data_0, 8'h66);
      step();

      // Counter wrap on port 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1, 0, W'(i), 1, 1, 1);
         step();
         if (i == 254) chk("wrap_ff_pre", Packet_Count_0, exp_cnt(8'hFE));
      end
      drive(0, 0, 8'h00, 0, 1, 1);
      step();
      chk("wrap_00", Packet_Count_0, exp_cnt(8'h00));

      // Random traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               W'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
